// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: shared commands, FSM states and defaults for the SPI flash responder
package spi_flash_pkg;
  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_JEDEC = 8'h9F;
  localparam logic [7:0] CMD_RDSR = 8'h05;
  localparam logic [23:0] JEDEC_DEFAULT = 24'hEF4016;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, ID, STAT, IGNORE} state_t;
endpackage

// File: rtl/spi_in_sync.sv
// spi_in_sync: 2-flop synchronizers for SCK/CS_N/MOSI plus SCK edge detect
module spi_in_sync (
  input  logic clk,
  input  logic reset,
  input  logic sck,
  input  logic cs_n,
  input  logic mosi,
  output logic sck_rise,
  output logic sck_fall,
  output logic cs_active,
  output logic mosi_s
);
  logic [1:0] sck_q, cs_q, mosi_q;
  logic sck_prev;
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_q <= '0;
      cs_q <= 2'b11;
      mosi_q <= '0;
      sck_prev <= 1'b0;
    end else begin
      sck_q <= {sck_q[0], sck};
      cs_q <= {cs_q[0], cs_n};
      mosi_q <= {mosi_q[0], mosi};
      sck_prev <= sck_q[1];
    end
  end
  assign sck_rise = sck_q[1] & ~sck_prev;
  assign sck_fall = ~sck_q[1] & sck_prev;
  assign cs_active = ~cs_q[1];
  assign mosi_s = mosi_q[1];
endmodule

// File: rtl/spi_flash_responder.sv
// spi_flash_responder: mode-0 SPI flash emulator serving READ, JEDEC ID and READ STATUS
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter logic [23:0] JEDEC_ID = JEDEC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sck,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);
  logic sck_rise, sck_fall, cs_active, mosi_s;
  state_t state;
  logic [2:0] bit_cnt;
  logic [1:0] phase, id_idx;
  logic [6:0] rx_shift;
  logic [7:0] rx_next, tx_shift, next_byte, id_byte;
  logic [ADDR_W-2:0] addr_sr;
  logic primed, rd_pend, rd_tx;

  spi_in_sync u_sync (
    .clk(clk), .reset(reset), .sck(sck), .cs_n(cs_n), .mosi(mosi),
    .sck_rise(sck_rise), .sck_fall(sck_fall), .cs_active(cs_active), .mosi_s(mosi_s)
  );

  assign rx_next = {rx_shift, mosi_s};
  assign id_byte = id_idx == 2'd1 ? JEDEC_ID[15:8] : id_idx == 2'd2 ? JEDEC_ID[7:0] : 8'h00;
  assign miso = miso_oe & tx_shift[7];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bit_cnt <= '0;
      phase <= '0;
      id_idx <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      next_byte <= '0;
      addr_sr <= '0;
      primed <= 1'b0;
      rd_pend <= 1'b0;
      rd_tx <= 1'b0;
      miso_oe <= 1'b0;
      mem_rd <= 1'b0;
      mem_addr <= '0;
      busy <= 1'b0;
    end else if (!cs_active) begin
      state <= IDLE;
      bit_cnt <= '0;
      phase <= '0;
      id_idx <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      next_byte <= '0;
      primed <= 1'b0;
      rd_pend <= 1'b0;
      miso_oe <= 1'b0;
      mem_rd <= 1'b0;
      busy <= 1'b0;
    end else begin
      busy <= 1'b1;
      mem_rd <= 1'b0;
      rd_pend <= mem_rd;
      if (rd_pend && rd_tx) tx_shift <= mem_rdata;
      if (rd_pend && !rd_tx) next_byte <= mem_rdata;
      if (sck_rise) begin
        bit_cnt <= bit_cnt + 3'd1;
        rx_shift <= rx_next[6:0];
        addr_sr <= {addr_sr[ADDR_W-3:0], mosi_s};
      end
      case (state)
        IDLE: state <= CMD;
        CMD: if (sck_rise && bit_cnt == 3'd7) begin
          state <= rx_next == CMD_READ ? ADDR : rx_next == CMD_JEDEC ? ID :
                   rx_next == CMD_RDSR ? STAT : IGNORE;
          miso_oe <= rx_next == CMD_JEDEC || rx_next == CMD_RDSR;
          tx_shift <= rx_next == CMD_JEDEC ? JEDEC_ID[23:16] : 8'h00;
          id_idx <= 2'd1;
          phase <= '0;
          primed <= 1'b0;
        end
        ADDR: if (sck_rise && bit_cnt == 3'd7) begin
          phase <= phase + 2'd1;
          if (phase == 2'd2) begin
            state <= DATA;
            miso_oe <= 1'b1;
            mem_addr <= {addr_sr, mosi_s};
            mem_rd <= 1'b1;
            rd_tx <= 1'b1;
            primed <= 1'b0;
          end
        end
        // The fall that ends the command/address byte precedes the first output bit, so skip it
        DATA, ID, STAT: if (sck_fall) begin
          if (!primed) primed <= 1'b1;
          else if (bit_cnt == 3'd0) begin
            tx_shift <= state == DATA ? next_byte : state == ID ? id_byte : 8'h00;
            if (state == ID) id_idx <= id_idx + {1'b0, id_idx != 2'd3};
          end else begin
            tx_shift <= {tx_shift[6:0], 1'b0};
            if (state == DATA && bit_cnt == 3'd1) begin
              mem_addr <= mem_addr + ADDR_W'(1);
              mem_rd <= 1'b1;
              rd_tx <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_flash_responder.sv
// tb_spi_flash_responder: directed SPI master transactions against a byte memory model
module tb_spi_flash_responder;
  logic clk = 0, reset = 1, sck = 0, cs_n = 1, mosi = 0;
  logic miso, miso_oe, mem_rd, busy;
  logic [15:0] mem_addr;
  logic [7:0] mem_rdata = 0;
  logic [7:0] mem [0:65535];
  logic [15:0] rd_log [$];
  int oe_cnt = 0;
  int checks = 0, failures = 0;
  logic [7:0] r, oe;

  spi_flash_responder dut (
    .clk(clk), .reset(reset), .sck(sck), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd) begin
      mem_rdata <= mem[mem_addr];
      rd_log.push_back(mem_addr);
    end
    if (miso_oe) oe_cnt <= oe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] o, input int n, output logic [7:0] ri, output logic [7:0] oi);
    ri = 0;
    oi = 0;
    for (int i = 7; i > 7 - n; i--) begin
      mosi = o[i];
      repeat (4) @(negedge clk);
      ri[i] = miso;
      oi[i] = miso_oe;
      sck = 1;
      repeat (4) @(negedge clk);
      sck = 0;
    end
  endtask

  task automatic cs_lo;
    cs_n = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_hi;
    repeat (4) @(negedge clk);
    cs_n = 1;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0010] = 8'hA5;
    mem[16'h0011] = 8'h3C;
    mem[16'hFFFF] = 8'h11;
    mem[16'h0000] = 8'h22;
    repeat (4) @(negedge clk);
    check("rst_miso", miso, 0);
    check("rst_oe", miso_oe, 0);
    check("rst_busy", busy, 0);
    reset = 0;
    repeat (4) @(negedge clk);
    check("idle_mem_rd", mem_rd, 0);
    check("idle_mem_addr", mem_addr, 0);

    // JEDEC ID
    cs_lo();
    check("id_busy", busy, 1);
    xfer(8'h9F, 8, r, oe);
    check("id_cmd_oe", oe, 8'h00);
    xfer(8'h00, 8, r, oe);
    check("id_b0", r, 8'hEF);
    check("id_b0_oe", oe, 8'hFF);
    xfer(8'h00, 8, r, oe);
    check("id_b1", r, 8'h40);
    xfer(8'h00, 8, r, oe);
    check("id_b2", r, 8'h16);
    xfer(8'h00, 8, r, oe);
    check("id_b3", r, 8'h00);
    cs_hi();
    check("id_end_oe", miso_oe, 0);
    check("id_end_busy", busy, 0);

    // READ at 0x10
    rd_log.delete();
    cs_lo();
    xfer(8'h03, 8, r, oe);
    xfer(8'h00, 8, r, oe);
    xfer(8'h00, 8, r, oe);
    xfer(8'h10, 8, r, oe);
    check("rd_addr_oe", oe, 8'h00);
    xfer(8'h00, 8, r, oe);
    check("rd_b0", r, 8'hA5);
    check("rd_b0_oe", oe, 8'hFF);
    xfer(8'h00, 8, r, oe);
    check("rd_b1", r, 8'h3C);
    cs_hi();
    check("rd_count", rd_log.size(), 3);
    if (rd_log.size() == 3) begin
      check("rd_a0", rd_log[0], 16'h0010);
      check("rd_a1", rd_log[1], 16'h0011);
      check("rd_a2", rd_log[2], 16'h0012);
    end

    // READ wrapping at 0xFFFF
    rd_log.delete();
    cs_lo();
    xfer(8'h03, 8, r, oe);
    xfer(8'h00, 8, r, oe);
    xfer(8'hFF, 8, r, oe);
    xfer(8'hFF, 8, r, oe);
    xfer(8'h00, 8, r, oe);
    check("wrap_b0", r, 8'h11);
    xfer(8'h00, 8, r, oe);
    check("wrap_b1", r, 8'h22);
    cs_hi();
    check("wrap_count", rd_log.size(), 3);
    if (rd_log.size() >= 2) begin
      check("wrap_a0", rd_log[0], 16'hFFFF);
      check("wrap_a1", rd_log[1], 16'h0000);
    end

    // Aborted command then READ STATUS
    cs_lo();
    xfer(8'h9F, 4, r, oe);
    cs_hi();
    check("abort_oe", miso_oe, 0);
    check("abort_busy", busy, 0);
    cs_lo();
    xfer(8'h05, 8, r, oe);
    xfer(8'h00, 8, r, oe);
    check("stat_b0", r, 8'h00);
    check("stat_oe", oe, 8'hFF);
    cs_hi();

    // Unknown command
    rd_log.delete();
    cs_lo();
    oe_cnt = 0;
    xfer(8'hAB, 8, r, oe);
    xfer(8'hFF, 8, r, oe);
    xfer(8'hFF, 8, r, oe);
    check("ign_oe_bits", oe, 8'h00);
    check("ign_oe_cycles", oe_cnt, 0);
    check("ign_reads", rd_log.size(), 0);
    cs_hi();

    // Reset in the middle of DATA
    cs_lo();
    xfer(8'h03, 8, r, oe);
    xfer(8'h00, 8, r, oe);
    xfer(8'h00, 8, r, oe);
    xfer(8'h10, 8, r, oe);
    xfer(8'h00, 4, r, oe);
    check("mid_oe_pre", miso_oe, 1);
    reset = 1;
    @(negedge clk);
    check("mrst_miso", miso, 0);
    check("mrst_oe", miso_oe, 0);
    check("mrst_mem_rd", mem_rd, 0);
    check("mrst_mem_addr", mem_addr, 0);
    check("mrst_busy", busy, 0);
    reset = 0;
    cs_hi();
    cs_lo();
    xfer(8'h03, 8, r, oe);
    xfer(8'h00, 8, r, oe);
    xfer(8'h00, 8, r, oe);
    xfer(8'h11, 8, r, oe);
    xfer(8'h00, 8, r, oe);
    check("post_rst_b0", r, 8'h3C);
    cs_hi();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_flash_responder.md
# spi_flash_responder

Synthesizable SPI mode-0 responder that emulates the serial boot flash seen by the RISC-V SoC's SPI master (CCK/MOSI/MISO/SPI_CS_N). It serves READ (0x03), JEDEC ID (0x9F) and READ STATUS (0x05) from an on-chip memory port. It sits in board-level simulation and in loop-back test builds in place of the external flash device. SCK, CS_N and MOSI are oversampled in the CLK domain.

## Interface
- ADDR_W, 16: memory address width; the 24-bit SPI address is truncated to ADDR_W LSBs.
- JEDEC_ID, 24'hEF4016: three ID bytes returned by 0x9F, MSB byte first.
- CLK  in  1  system clock; SCK must be at most CLK/8.
- RESET  in  1  synchronous, active-high reset.
- SCK  in  1  SPI clock from master; asynchronous; idle low (mode 0).
- CS_N  in  1  chip select, active low; asynchronous.
- MOSI  in  1  serial data from master; asynchronous.
- MISO  out  1  serial data to master.
- MISO_OE  out  1  MISO output enable; the top level tri-states MISO when this is 0.
- MEM_ADDR  out  ADDR_W  byte address to the memory.
- MEM_RD  out  1  single-cycle read strobe.
- MEM_RDATA  in  8  read data, valid exactly one CLK after MEM_RD.
- BUSY  out  1  high while CS_N (synchronized) is low.

## Operation
- Synchronizers: 2-flop synchronizers on SCK, CS_N and MOSI, plus one history flop on SCK for edge detection.
  - Rise = SCK sync 1 and previous 0; fall = the converse.
  - MOSI is sampled on rise, MSB first. MISO shifts on fall.
- FSM states and transitions:
  - IDLE: entered on reset or when CS_N goes high. CS_N falling goes to CMD.
  - CMD: after 8 bits, the command byte decodes as 0x03 → ADDR, 0x9F → ID, 0x05 → STAT, any other value → IGNORE.
  - ADDR: after 24 bits, the address register latches the low ADDR_W bits, then the state goes to DATA.
  - DATA: streams bytes with no length limit.
    - The address increments after each byte is loaded and wraps from 2^ADDR_W−1 to 0.
  - ID: sends JEDEC_ID bytes 2,1,0, then 0x00 forever.
  - STAT: sends 0x00 repeatedly (never busy, no write-enable).
  - IGNORE: MISO_OE stays 0 until CS_N goes high.
- CS_N high in any state forces IDLE on the next CLK. This clears the bit counter and shift registers and drops MISO_OE. A partial byte is discarded.
- MISO_OE is 1 only in DATA, ID and STAT. MISO = tx_shift[7] when enabled, 0 otherwise.
- Byte prefetch:
  - On entry to DATA, MEM_RD pulses with MEM_ADDR = latched address. The next CLK loads MEM_RDATA into tx_shift.
  - On the first fall of each byte, MEM_RD pulses for address+1. The result is held in a next-byte register and loaded into tx_shift on the 8th fall.
- A bit counter (3 bits) and a byte phase counter (for ADDR, 2 bits) wrap naturally.
- Reset values: MISO 0, MISO_OE 0, MEM_RD 0, MEM_ADDR 0, BUSY 0, state IDLE.

## Timing
- Input-to-internal latency is 3 CLK (2 sync + edge detect) from a pin transition.
- MISO updates 1 CLK after the internal fall detect, i.e. ≤4 CLK after the pin falling edge.
  - At SCK ≤ CLK/8, the half period is ≥4 CLK, so setup to the master's rising edge is met.
- The first data bit (bit 7 of byte 0) must be on MISO before the 33rd SCK rising edge (READ) or the 9th (ID/STAT).
  - The last address or command bit is detected on rise. MEM_RD follows +1 CLK, data is loaded +2 CLK, and MISO is valid +3 CLK, which is within the low half period.
- MEM_RD is never asserted on two consecutive cycles. At most one read is outstanding.
- Simultaneous SCK edge and CS_N rise: CS_N wins and the edge is ignored.

## Structure
- Shared package spi_flash_pkg holds:
  - command constants CMD_READ=8'h03, CMD_JEDEC=8'h9F, CMD_RDSR=8'h05;
  - the state enum (IDLE, CMD, ADDR, DATA, ID, STAT, IGNORE);
  - the default JEDEC_ID.
- One sub-module, spi_in_sync: 2-flop synchronizers plus SCK rise/fall detect, outputting sck_rise, sck_fall, cs_active, mosi_s.
- Everything else lives in spi_flash_responder.

## Test plan
- 0x9F with 24 SCK of dummy MOSI → MISO returns EF, 40, 16; MISO_OE high only after the 8th SCK.
- READ 0x03, addr 0x000010, mem[0x10]=A5, mem[0x11]=3C, 16 SCK → A5, 3C.
  - MEM_RD pulses for addresses 0x10, 0x11 and 0x12.
- READ at 0x00FFFF (ADDR_W=16), 2 bytes, mem[FFFF]=11, mem[0]=22 → 11, 22 (address wrap).
- CS_N deasserted after 4 bits of a command byte → IDLE, MISO_OE=0. A following 0x05 returns 00.
- Unknown command 0xAB followed by 16 SCK → MISO_OE stays 0 and MEM_RD never pulses.
- RESET asserted mid-DATA, SCK=CLK/8 → all outputs at reset values the next CLK. A new READ after CS_N toggles works.
